bft_leaf_port: RTL and testbench

// - Parametrised leaf-side endpoint between one PE and one leaf of the butterfly-fat-tree (BFT).
// - Converts PE valid/ready streams into BFT leaf packets {valid, dest_addr, payload} on dout_leaf.
// - Re-presents any packet rejected via resend; buffers inbound din_leaf packets for the PE.
// - Sits between each PE and the gen_nw* network, replacing direct PE-to-leaf wiring; one instance per leaf.

---
 rtl/bft_leaf_port.sv | 126 ++++++++++++
 tb/tb_bft_leaf_port.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bft_leaf_port.sv
// bft_leaf_port: PE <-> BFT leaf endpoint with TX/RX FIFOs, resend hold and local loopback.
// Optional BFT_LEAF_STATS_EN adds saturating 32-bit traffic counters.
module bft_leaf_port #(
    parameter int NUM_LEAVES = 8,
    parameter int PAYLOAD_SZ = 45,
    parameter int LEAF_ADDR  = 0,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4,
    localparam int ADDR_W    = $clog2(NUM_LEAVES),
    localparam int P_SZ      = 1 + ADDR_W + PAYLOAD_SZ
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [ADDR_W-1:0]     tx_dest,
    input  logic [PAYLOAD_SZ-1:0] tx_payload,
    output logic [P_SZ-1:0]       dout_leaf,
    input  logic                  resend,
    input  logic [P_SZ-1:0]       din_leaf,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [PAYLOAD_SZ-1:0] rx_payload,
    output logic                  rx_drop
`ifdef BFT_LEAF_STATS_EN
    ,
    output logic [31:0]           stat_tx_pkts,
    output logic [31:0]           stat_tx_resends,
    output logic [31:0]           stat_rx_pkts,
    output logic [31:0]           stat_rx_drops
`endif
);
    localparam int E_SZ = ADDR_W + PAYLOAD_SZ;
    localparam int TA = $clog2(TX_DEPTH);
    localparam int RA = $clog2(RX_DEPTH);
    localparam logic [ADDR_W-1:0] MY = ADDR_W'(LEAF_ADDR);
    localparam logic [TA:0] T_ONE = (TA + 1)'(1);
    localparam logic [RA:0] R_ONE = (RA + 1)'(1);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    state_t                state;
    logic [E_SZ-1:0]       tx_mem [TX_DEPTH];
    logic [PAYLOAD_SZ-1:0] rx_mem [RX_DEPTH];
    logic [TA:0]           tx_wp, tx_rp, tx_rp1;
    logic [RA:0]           rx_wp, rx_rp;
    logic [E_SZ-1:0]       head, nxt;
    logic tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, accept;
    logic mem_next, nxt_ok, net_wr, lb_go, rx_pop, rx_wr;

    assign tx_empty = tx_wp == tx_rp;
    assign tx_full  = (tx_wp[TA] != tx_rp[TA]) && (tx_wp[TA-1:0] == tx_rp[TA-1:0]);
    assign tx_ready = !tx_full && !reset;
    assign tx_push  = tx_valid && tx_ready;
    assign head     = tx_mem[tx_rp[TA-1:0]];
    assign tx_rp1   = tx_rp + T_ONE;
    // The entry behind the head may still be arriving this cycle; forward it to avoid a bubble.
    assign mem_next = tx_rp1 != tx_wp;
    assign nxt      = mem_next ? tx_mem[tx_rp1[TA-1:0]] : {tx_dest, tx_payload};
    assign nxt_ok   = (mem_next || tx_push) && nxt[E_SZ-1 -: ADDR_W] != MY;
    assign accept   = state != IDLE && !resend;
    assign net_wr   = din_leaf[P_SZ-1] && din_leaf[P_SZ-2 -: ADDR_W] == MY;
    // Loopback yields the single RX write port to network arrivals.
    assign lb_go    = state == IDLE && !tx_empty && head[E_SZ-1 -: ADDR_W] == MY && !net_wr && !rx_full;
    assign tx_pop   = accept || lb_go;

    assign rx_empty   = rx_wp == rx_rp;
    assign rx_full    = (rx_wp[RA] != rx_rp[RA]) && (rx_wp[RA-1:0] == rx_rp[RA-1:0]);
    assign rx_valid   = !rx_empty;
    assign rx_payload = rx_mem[rx_rp[RA-1:0]];
    assign rx_pop     = rx_valid && rx_ready;
    assign rx_wr      = (net_wr || lb_go) && (!rx_full || rx_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dout_leaf <= '0;
            tx_wp     <= '0;
            tx_rp     <= '0;
            rx_wp     <= '0;
            rx_rp     <= '0;
            rx_drop   <= 1'b0;
        end else begin
            tx_wp   <= tx_push ? tx_wp + T_ONE : tx_wp;
            tx_rp   <= tx_pop ? tx_rp1 : tx_rp;
            rx_wp   <= rx_wr ? rx_wp + R_ONE : rx_wp;
            rx_rp   <= rx_pop ? rx_rp + R_ONE : rx_rp;
            rx_drop <= net_wr && rx_full && !rx_pop;
            if (state == IDLE) begin
                if (!tx_empty && head[E_SZ-1 -: ADDR_W] != MY) begin
                    state     <= SEND;
                    dout_leaf <= {1'b1, head};
                end
            end else if (resend) begin
                state <= HOLD;
            end else if (nxt_ok) begin
                state     <= SEND;
                dout_leaf <= {1'b1, nxt};
            end else begin
                state     <= IDLE;
                dout_leaf <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[TA-1:0]] <= {tx_dest, tx_payload};
        if (rx_wr) rx_mem[rx_wp[RA-1:0]] <= net_wr ? din_leaf[PAYLOAD_SZ-1:0] : head[PAYLOAD_SZ-1:0];
    end

`ifdef BFT_LEAF_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_tx_pkts    <= '0;
            stat_tx_resends <= '0;
            stat_rx_pkts    <= '0;
            stat_rx_drops   <= '0;
        end else begin
            stat_tx_pkts    <= stat_tx_pkts + 32'(accept && stat_tx_pkts != '1);
            stat_tx_resends <= stat_tx_resends + 32'(state != IDLE && resend && stat_tx_resends != '1);
            stat_rx_pkts    <= stat_rx_pkts + 32'(rx_wr && stat_rx_pkts != '1);
            stat_rx_drops   <= stat_rx_drops + 32'(rx_drop && stat_rx_drops != '1);
        end
    end
`endif
endmodule

// File: tb/tb_bft_leaf_port.sv
// tb_bft_leaf_port: directed stimulus with queue scoreboards for the network and PE receive streams.
module tb_bft_leaf_port;
    logic        clk = 1'b0, reset = 1'b0, tx_valid = 1'b0, resend = 1'b0, rx_ready = 1'b0;
    logic [2:0]  tx_dest = '0;
    logic [44:0] tx_payload = '0;
    logic [48:0] din_leaf = '0;
    logic        tx_ready, rx_valid, rx_drop;
    logic [48:0] dout_leaf;
    logic [44:0] rx_payload;
`ifdef BFT_LEAF_STATS_EN
    logic [31:0] s_tp, s_tr, s_rp, s_rd;
`endif
    int checks = 0, failures = 0, drops = 0, d0;
    logic [48:0] exp_net[$];
    logic [44:0] exp_rx[$];

    bft_leaf_port dut (
        .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_dest(tx_dest), .tx_payload(tx_payload), .dout_leaf(dout_leaf),
        .resend(resend), .din_leaf(din_leaf), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_payload(rx_payload), .rx_drop(rx_drop)
`ifdef BFT_LEAF_STATS_EN
        , .stat_tx_pkts(s_tp), .stat_tx_resends(s_tr), .stat_rx_pkts(s_rp), .stat_rx_drops(s_rd)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] d, input logic [44:0] p);
        int n = 0;
        tx_dest = d;
        tx_payload = p;
        tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk("push_timeout", tx_ready, 1);
        @(posedge clk);
        if (d != 3'd0) exp_net.push_back({1'b1, d, p});
        #1 tx_valid = 1'b0;
    endtask

    task automatic drain(input bit rx, input string name);
        int n = 0;
        while ((rx ? exp_rx.size() : exp_net.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, rx ? exp_rx.size() : exp_net.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rx_drop === 1'b1) drops++;
        if (dout_leaf[48] === 1'b1) begin
            if (exp_net.size() == 0) chk("net_unexpected", dout_leaf, 0);
            else begin
                chk("net_pkt", dout_leaf, exp_net[0]);
                if (resend == 1'b0) void'(exp_net.pop_front());
            end
        end
        if (rx_valid === 1'b1 && rx_ready) begin
            if (exp_rx.size() == 0) chk("rx_unexpected", rx_valid, 0);
            else chk("rx_payload", rx_payload, exp_rx.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_dout", dout_leaf, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_drop", rx_drop, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick;

        // single packet, accepted first time
        push(3'd5, 45'h1234);
        @(negedge clk) chk("t1_latency", dout_leaf, 0);
        @(negedge clk) chk("t1_dout", dout_leaf, 49'h1_A000_0000_1234);
        @(negedge clk) chk("t1_after", dout_leaf, 0);
        tick;

        // three rejections, then the queued packet follows with no gap
        resend = 1'b1;
        push(3'd5, 45'h1111);
        push(3'd3, 45'h2222);
        begin
            int n = 0;
            @(negedge clk);
            while (dout_leaf[48] !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("t2_valid_seen", dout_leaf[48], 1);
        end
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 resend = 1'b0;
        @(negedge clk) chk("t2_held4", dout_leaf, 49'h1_A000_0000_1111);
        @(negedge clk) chk("t2_b2b", dout_leaf, 49'h1_6000_0000_2222);
        @(negedge clk) chk("t2_idle", dout_leaf, 0);
        tick;

        // TX back-pressure
        resend = 1'b1;
        push(3'd1, 45'h51);
        push(3'd2, 45'h52);
        push(3'd3, 45'h53);
        push(3'd4, 45'h54);
        @(negedge clk) chk("t3_full", tx_ready, 0);
        fork
            push(3'd5, 45'h55);
            begin
                repeat (3) @(negedge clk);
                chk("t3_still_full", tx_ready, 0);
                @(posedge clk);
                #1 resend = 1'b0;
                @(negedge clk) chk("t3_pop_cycle", tx_ready, 0);
                @(negedge clk) chk("t3_freed", tx_ready, 1);
            end
        join
        drain(1'b0, "t3_drain");
        tick;

        // RX overflow: foreign packet ignored, 4 stored, 2 dropped
        d0 = drops;
        din_leaf = {1'b1, 3'd3, 45'h99};
        for (int i = 0; i < 6; i++) begin
            tick;
            din_leaf = {1'b1, 3'd0, 45'(160 + i)};
            if (i < 4) exp_rx.push_back(45'(160 + i));
        end
        tick;
        din_leaf = '0;
        repeat (3) @(negedge clk);
        chk("t4_drops", drops - d0, 2);
        chk("t4_rx_valid", rx_valid, 1);
`ifdef BFT_LEAF_STATS_EN
        chk("t4_stat_drops", s_rd, 2);
        chk("t4_stat_rx", s_rp, 4);
        chk("t4_stat_tx", s_tp, 8);
`endif
        tick;
        rx_ready = 1'b1;
        drain(1'b1, "t4_drain");
        @(negedge clk) chk("t4_rx_empty", rx_valid, 0);
        tick;

        // loopback loses arbitration to a same-cycle network arrival
        push(3'd0, 45'hCC);
        din_leaf = {1'b1, 3'd0, 45'hBB};
        exp_rx.push_back(45'hBB);
        exp_rx.push_back(45'hCC);
        tick;
        din_leaf = '0;
        @(negedge clk) chk("t5_no_net", dout_leaf, 0);
        drain(1'b1, "t5_drain");
        tick;

        // reset while holding with a queue behind
        resend = 1'b1;
        push(3'd2, 45'h61);
        push(3'd3, 45'h62);
        push(3'd4, 45'h63);
        tick;
        reset = 1'b1;
        #1;
        chk("t6_dout_now", dout_leaf, 0);
        chk("t6_tx_ready", tx_ready, 0);
        exp_net.delete();
        repeat (2) tick;
        reset = 1'b0;
        resend = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_no_stale", dout_leaf, 0);
        chk("t6_rx_valid", rx_valid, 0);
        chk("t6_tx_ready_after", tx_ready, 1);
`ifdef BFT_LEAF_STATS_EN
        chk("t6_stats", {s_tp | s_tr, s_rp | s_rd}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
